// File: rtl/traffic_light_monitor.sv
// Lamp-side safety monitor for a four-head intersection: validates lamp codes,
// sequencing, yellow/green durations and green conflicts, latching a fault that forces all heads red.
module traffic_light_monitor #(
    parameter int MAX_GREENS    = 1,
    parameter int MIN_YELLOW    = 2,
    parameter int MAX_GREEN_SMP = 200,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             attention,
    input  logic [3:0][0:2]  ltfs,
    input  logic             clear,
    output logic [3:0]       force_reds,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       fault_head
);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

    // Lamp codes as {red, yellow, green}
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    localparam logic [CNT_W-1:0] MIN_Y_CNT   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_G_CNT   = CNT_W'(MAX_GREEN_SMP);
    localparam logic [2:0]       MAX_G_HEADS = 3'(MAX_GREENS);

    state_t                 state_reg;
    logic [3:0][2:0]        prev_reg;
    logic [3:0][CNT_W-1:0]  ycnt_reg;
    logic [3:0][CNT_W-1:0]  gcnt_reg;
    logic [3:0][CNT_W-1:0]  ycnt_next;
    logic [3:0][CNT_W-1:0]  gcnt_next;
    logic                   att_prev_reg;
    logic                   fault_reg;
    logic [2:0]             code_reg;
    logic [1:0]             head_reg;

    logic [3:0] green_vec;
    logic [3:0] code_bad;
    logic [3:0] trans_bad;
    logic [3:0] short_bad;
    logic [3:0] tmo_bad;
    logic       seq_check;
    logic [2:0] n_green;
    logic       conflict;
    logic [2:0] viol_code;
    logic [1:0] viol_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Sequence checks are suppressed in attention mode and on the first sample leaving it
    assign seq_check = (state_reg == S_RUN) && !attention && !att_prev_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_head
        logic [2:0] cur;
        logic [2:0] prv;
        logic       trans_ok;

        assign cur = ltfs[gi];
        assign prv = prev_reg[gi];

        // Any lit green filament counts toward a conflict, even inside an illegal code
        assign green_vec[gi] = cur[0];
        assign code_bad[gi]  = attention ? !(cur == L_OFF || cur == L_YEL)
                                         : !(cur == L_RED || cur == L_YEL || cur == L_GRN);

        assign trans_ok = (cur == prv)
                       || (prv == L_RED && cur == L_GRN)
                       || (prv == L_GRN && cur == L_YEL)
                       || (prv == L_YEL && cur == L_RED);

        assign trans_bad[gi] = seq_check && !trans_ok;
        assign short_bad[gi] = seq_check && (prv == L_YEL) && (cur == L_RED)
                            && (ycnt_reg[gi] < MIN_Y_CNT);

        assign ycnt_next[gi] = (!attention && cur == L_YEL) ? sat_inc(ycnt_reg[gi]) : '0;
        assign gcnt_next[gi] = (!attention && cur == L_GRN) ? sat_inc(gcnt_reg[gi]) : '0;
        assign tmo_bad[gi]   = (state_reg == S_RUN) && (gcnt_next[gi] != '0)
                            && (gcnt_next[gi] >= MAX_G_CNT);
    end

    always_comb begin
        n_green = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n_green = n_green + {2'b00, green_vec[i]};
        end
        conflict = (n_green > MAX_G_HEADS);
    end

    // Lowest code wins; outside RUN only conflict and code violations can be nonzero
    always_comb begin
        viol_code = 3'd0;
        viol_head = 2'd0;
        if (conflict) begin
            viol_code = 3'd1;
            viol_head = lowest(green_vec);
        end else if (|code_bad) begin
            viol_code = 3'd2;
            viol_head = lowest(code_bad);
        end else if (|trans_bad) begin
            viol_code = 3'd3;
            viol_head = lowest(trans_bad);
        end else if (|short_bad) begin
            viol_code = 3'd4;
            viol_head = lowest(short_bad);
        end else if (|tmo_bad) begin
            viol_code = 3'd5;
            viol_head = lowest(tmo_bad);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_INIT;
            prev_reg     <= '0;
            ycnt_reg     <= '0;
            gcnt_reg     <= '0;
            att_prev_reg <= 1'b0;
            fault_reg    <= 1'b0;
            code_reg     <= 3'd0;
            head_reg     <= 2'd0;
        end else if (sample_en) begin
            prev_reg     <= ltfs;
            att_prev_reg <= attention;
            case (state_reg)
                S_INIT: begin
                    ycnt_reg <= '0;
                    gcnt_reg <= '0;
                    if (viol_code != 3'd0) begin
                        state_reg <= S_FAULT;
                        fault_reg <= 1'b1;
                        code_reg  <= viol_code;
                        head_reg  <= viol_head;
                    end else begin
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (viol_code != 3'd0) begin
                        state_reg <= S_FAULT;
                        fault_reg <= 1'b1;
                        code_reg  <= viol_code;
                        head_reg  <= viol_head;
                        ycnt_reg  <= '0;
                        gcnt_reg  <= '0;
                    end else begin
                        ycnt_reg <= ycnt_next;
                        gcnt_reg <= gcnt_next;
                    end
                end
                S_FAULT: begin
                    ycnt_reg <= '0;
                    gcnt_reg <= '0;
                    if (clear && viol_code == 3'd0) begin
                        state_reg <= S_INIT;
                        fault_reg <= 1'b0;
                        code_reg  <= 3'd0;
                        head_reg  <= 2'd0;
                    end
                end
                default: state_reg <= S_INIT;
            endcase
        end
    end

    assign fault      = fault_reg;
    assign fault_code = code_reg;
    assign fault_head = head_reg;
    assign force_reds = {4{fault_reg}};

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a default instance and one with a short green timeout,
// driven from directed lamp vectors; a monitor compares outputs after every sampled edge.
module tb_traffic_light_monitor;

    typedef logic [3:0][0:2] lamps_t;
    typedef struct {
        logic [9:0] v;
        int         id;
    } exp_t;

    localparam logic [0:2] R = 3'b100;
    localparam logic [0:2] Y = 3'b010;
    localparam logic [0:2] G = 3'b001;
    localparam logic [0:2] O = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_en = 1'b0;
    logic       sample_en4 = 1'b0;
    logic       attention = 1'b0;
    logic       clear = 1'b0;
    lamps_t     ltfs = '0;

    logic [3:0] force_reds,  force_reds4;
    logic       fault,       fault4;
    logic [2:0] fault_code,  fault_code4;
    logic [1:0] fault_head,  fault_head4;

    int   checks = 0;
    int   errors = 0;
    int   n_smp  = 0;
    exp_t q0[$];
    exp_t q4[$];
    exp_t e_mon;
    logic mon_s0, mon_s4;

    traffic_light_monitor u_dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .attention(attention),
        .ltfs(ltfs), .clear(clear), .force_reds(force_reds), .fault(fault),
        .fault_code(fault_code), .fault_head(fault_head)
    );

    traffic_light_monitor #(.MAX_GREEN_SMP(4)) u_dut4 (
        .clk(clk), .rst(rst), .sample_en(sample_en4), .attention(attention),
        .ltfs(ltfs), .clear(clear), .force_reds(force_reds4), .fault(fault4),
        .fault_code(fault_code4), .fault_head(fault_head4)
    );

    always #5 clk = ~clk;

    function automatic lamps_t L(input logic [0:2] h0, input logic [0:2] h1,
                                 input logic [0:2] h2, input logic [0:2] h3);
        return {h3, h2, h1, h0};
    endfunction

    function automatic logic [9:0] pack_exp(input logic f, input logic [2:0] c, input logic [1:0] h);
        return {f, c, h, {4{f}}};
    endfunction

    task automatic cmp(input string nm, input int id, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got fault=%b code=%0d head=%0d force=%h, expected fault=%b code=%0d head=%0d force=%h",
                     nm, id, act[9], act[8:6], act[5:4], act[3:0], exp[9], exp[8:6], exp[5:4], exp[3:0]);
        end else begin
            $display("%s #%0d: fault=%b code=%0d head=%0d force=%h ok",
                     nm, id, act[9], act[8:6], act[5:4], act[3:0]);
        end
    endtask

    // Issue one sample, push its expected response, then idle a cycle with garbage on the inputs
    task automatic smp(input lamps_t l, input logic att, input logic clr, input bit to4,
                       input logic f, input logic [2:0] c, input logic [1:0] h);
        exp_t e;
        @(negedge clk);
        ltfs      = l;
        attention = att;
        clear     = clr;
        e.v  = pack_exp(f, c, h);
        e.id = n_smp;
        n_smp++;
        if (to4) begin
            sample_en4 = 1'b1;
            q4.push_back(e);
        end else begin
            sample_en = 1'b1;
            q0.push_back(e);
        end
        @(negedge clk);
        sample_en  = 1'b0;
        sample_en4 = 1'b0;
        ltfs       = {4{3'b111}};
        attention  = ~att;
        clear      = ~clr;
    endtask

    task automatic s0(input lamps_t l, input logic att, input logic clr,
                      input logic f, input logic [2:0] c, input logic [1:0] h);
        smp(l, att, clr, 1'b0, f, c, h);
    endtask

    task automatic s4(input lamps_t l, input logic att, input logic clr,
                      input logic f, input logic [2:0] c, input logic [1:0] h);
        smp(l, att, clr, 1'b1, f, c, h);
    endtask

    // Monitor: every sampled edge must have a queued expectation for that instance
    always @(posedge clk) begin
        mon_s0 = sample_en;
        mon_s4 = sample_en4;
        #1;
        if (mon_s0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut: sample with no expected entry");
            end else begin
                e_mon = q0.pop_front();
                cmp("dut", e_mon.id, {fault, fault_code, fault_head, force_reds}, e_mon.v);
            end
        end
        if (mon_s4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4: sample with no expected entry");
            end else begin
                e_mon = q4.pop_front();
                cmp("dut4", e_mon.id, {fault4, fault_code4, fault_head4, force_reds4}, e_mon.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        cmp("reset_dut",  -1, {fault,  fault_code,  fault_head,  force_reds},  pack_exp(1'b0, 3'd0, 2'd0));
        cmp("reset_dut4", -1, {fault4, fault_code4, fault_head4, force_reds4}, pack_exp(1'b0, 3'd0, 2'd0));
        @(negedge clk);
        rst = 1'b0;

        // Normal cycle on head0
        s0(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        for (int i = 0; i < 5; i++) s0(L(G,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(Y,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(Y,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);

        // Conflict: heads 1 and 3 green
        s0(L(R,G,R,G), 0, 0, 1, 3'd1, 2'd1);
        s0(L(R,R,R,R), 0, 1, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);

        // Illegal transition: head2 green straight to red
        s0(L(R,R,G,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 1, 3'd3, 2'd2);
        s0(L(R,R,R,R), 0, 1, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);

        // Short yellow on head0
        s0(L(G,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(Y,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 1, 3'd4, 2'd0);
        s0(L(R,R,R,R), 0, 1, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);

        // Illegal codes on heads 0 and 1, then a conflict while faulted
        s0(L(3'b011,3'b110,R,R), 0, 0, 1, 3'd2, 2'd0);
        s0(L(G,G,R,R), 0, 0, 1, 3'd2, 2'd0);

        // Clear refused while violating, accepted on clean lamps; INIT skips transition check
        s0(L(G,G,R,R), 0, 1, 1, 3'd2, 2'd0);
        s0(L(R,R,3'b111,R), 0, 1, 1, 3'd2, 2'd0);
        s0(L(R,R,R,R), 0, 1, 0, 3'd0, 2'd0);
        s0(L(Y,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(Y,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(Y,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 1, 0, 3'd0, 2'd0);

        // Attention mode: yellow/off toggling, return to normal without transition check
        s0(L(Y,O,Y,O), 1, 0, 0, 3'd0, 2'd0);
        s0(L(O,Y,O,Y), 1, 0, 0, 3'd0, 2'd0);
        s0(L(Y,Y,O,O), 1, 0, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(G,O,O,O), 1, 0, 1, 3'd2, 2'd0);
        s0(L(O,O,O,O), 1, 1, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(R,R,3'b111,R), 0, 0, 1, 3'd2, 2'd2);

        // Green timeout on the short-timeout instance
        s4(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s4(L(R,R,R,G), 0, 0, 0, 3'd0, 2'd0);
        s4(L(R,R,R,G), 0, 0, 0, 3'd0, 2'd0);
        s4(L(R,R,R,G), 0, 0, 0, 3'd0, 2'd0);
        s4(L(R,R,R,G), 0, 0, 1, 3'd5, 2'd3);

        // Asynchronous reset mid-fault, checked between clock edges
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_dut",  -1, {fault,  fault_code,  fault_head,  force_reds},  pack_exp(1'b0, 3'd0, 2'd0));
        cmp("async_rst_dut4", -1, {fault4, fault_code4, fault_head4, force_reds4}, pack_exp(1'b0, 3'd0, 2'd0));
        @(negedge clk);
        rst = 1'b0;
        s4(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);
        s0(L(R,R,R,R), 0, 0, 0, 3'd0, 2'd0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, required 0/0", q0.size(), q4.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
